// File: rtl/q_8_28_op_sequencer.sv
// q_8_28_op_sequencer
//   Feeds operand pairs to the q_8_28 one-hot shift-add multiplier and collects
//   its results. Pairs arrive on a valid/ready source and wait in a small FIFO.
//   Each pair is issued with the multiplier's start/rdy handshake. The product
//   and its two operands are returned on a valid/ready sink. A watchdog drops a
//   job, and raises a sticky timeout, if the multiplier never finishes.
//
// Ports
//   clk, rst_b                       clock (rising edge), async active-low reset
//   in_valid/in_ready                operand source handshake
//   in_multiplicand/in_multiplier    operand pair offered by the source
//   start, multiplicand, multiplier  issue side toward the multiplier
//   rdy, product                     multiplier status (1 = idle/done) and result
//   out_valid/out_ready              result sink handshake
//   out_product/out_mcand/out_mplier captured result and its operands
//   timeout                          sticky watchdog flag
//   job_count                        results delivered, wraps
module q_8_28_op_sequencer #(
  parameter int DP_WIDTH   = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_LIMIT = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DP_WIDTH-1:0]     in_multiplicand,
  input  logic [DP_WIDTH-1:0]     in_multiplier,
  output logic                    start,
  output logic [DP_WIDTH-1:0]     multiplicand,
  output logic [DP_WIDTH-1:0]     multiplier,
  input  logic                    rdy,
  input  logic [2*DP_WIDTH-1:0]   product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DP_WIDTH-1:0]   out_product,
  output logic [DP_WIDTH-1:0]     out_mcand,
  output logic [DP_WIDTH-1:0]     out_mplier,
  output logic                    timeout,
  output logic [CNT_WIDTH-1:0]    job_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WD_W   = $clog2(BUSY_LIMIT + 1);
  localparam int PAIR_W = 2 * DP_WIDTH;

  localparam logic [PTR_W:0]     PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(BUSY_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    DELIVER   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic [PAIR_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PAIR_W-1:0]     mem_d [FIFO_DEPTH];
  logic                  has_data_q, has_data_d;
  logic [DP_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DP_WIDTH-1:0]   mplier_q, mplier_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [WD_W-1:0]       wdog_inc;
  logic                  timeout_q, timeout_d;
  logic                  out_valid_q, out_valid_d;
  logic [PAIR_W-1:0]     out_product_q, out_product_d;
  logic [DP_WIDTH-1:0]   out_mcand_q, out_mcand_d;
  logic [DP_WIDTH-1:0]   out_mplier_q, out_mplier_d;
  logic [CNT_WIDTH-1:0]  job_count_q, job_count_d;

  logic                  full, empty, push, pop;
  logic [PAIR_W-1:0]     head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // No bypass: a pop in the same cycle does not open a full queue.
  assign in_ready = rst_b && !full;
  assign push     = in_valid && in_ready;

  // Occupancy seen by the FSM is registered, so a fresh push launches two
  // edges later. The stale value right after a pop is harmless: IDLE is never
  // re-entered sooner than two cycles after leaving it.
  assign has_data_d = !empty;

  assign wdog_inc = wdog_q + WD_ONE;

  assign multiplicand = mcand_q;
  assign multiplier   = mplier_q;
  assign out_valid    = out_valid_q;
  assign out_product  = out_product_q;
  assign out_mcand    = out_mcand_q;
  assign out_mplier   = out_mplier_q;
  assign timeout      = timeout_q;
  assign job_count    = job_count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {in_multiplicand, in_multiplier};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    start         = 1'b0;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    wdog_d        = wdog_q;
    timeout_d     = timeout_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_mcand_d   = out_mcand_q;
    out_mplier_d  = out_mplier_q;
    job_count_d   = job_count_q;

    case (state_q)
      IDLE: begin
        if (has_data_q && rdy) begin
          pop      = 1'b1;
          mcand_d  = head[PAIR_W-1:DP_WIDTH];
          mplier_d = head[DP_WIDTH-1:0];
          wdog_d   = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        start  = 1'b1;
        wdog_d = wdog_inc;
        // The watchdog takes priority: an expired job is dropped silently.
        if (wdog_inc == WD_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (!rdy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wdog_d = wdog_inc;
        if (wdog_inc == WD_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (rdy) begin
          out_product_d = product;
          out_mcand_d   = mcand_q;
          out_mplier_d  = mplier_q;
          out_valid_d   = 1'b1;
          state_d       = DELIVER;
        end
      end
      DELIVER: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          job_count_d = job_count_q + CNT_ONE;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      has_data_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      has_data_q <= has_data_d;
      mem_q      <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_mcand_q   <= '0;
      out_mplier_q  <= '0;
      job_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_mcand_q   <= out_mcand_d;
      out_mplier_q  <= out_mplier_d;
      job_count_q   <= job_count_d;
    end
  end

endmodule
